// File: rtl/dot_acc_pkg.sv
// Shared types and constants for the dot_acc streaming accumulator.
package dot_acc_pkg;

    localparam int PROD_W    = 32;
    localparam int DEF_ACC_W = 40;
    localparam int DEF_CNT_W = 8;

    // ST_ACCUM: accepting beats; ST_STALL: finished frame parked in acc, waiting for output slot
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/dot_acc_sat_add.sv
// Unsigned saturating adder: ACC_W accumulator plus zero-extended 32-bit product.
module sat_add
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] full;

    // One extra bit catches the carry-out; any carry clamps the result to all-ones.
    always_comb begin
        full = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
        ovf  = full[ACC_W];
        sum  = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
    end

endmodule

// File: rtl/dot_acc.sv
// Frame accumulator behind the 16x16 multiplier: sums products until a last
// beat, then hands the saturated sum, beat count and sat flag to a one-entry
// output register. A finished frame that finds the output busy parks in the
// accumulator (STALL) and input is held off until it moves out.
//
// state    | meaning
// ST_ACCUM | prod_ready_o = 1, summing beats of the current frame
// ST_STALL | prod_ready_o = 0, acc/cnt/sat hold a finished frame
module dot_acc
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    input  logic              prod_last_i,
    output logic              prod_ready_o,
    output logic [ACC_W-1:0]  res_o,
    output logic [CNT_W-1:0]  res_cnt_o,
    output logic              res_sat_o,
    output logic              res_valid_o,
    input  logic              res_ready_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             res_sat_q, res_sat_d;
    logic             res_valid_q, res_valid_d;

    logic [ACC_W-1:0] nsum;
    logic             ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat_acc;
    logic             out_free;
    logic             load;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (prod_i),
        .sum (nsum),
        .ovf (ovf)
    );

    // Ready depends on registered state only, so res_ready_i never reaches prod_ready_o.
    assign prod_ready_o = (state_q == ST_ACCUM);
    assign beat_acc     = prod_valid_i && prod_ready_o;
    assign out_free     = !res_valid_q || res_ready_i;
    assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    assign res_o       = res_q;
    assign res_cnt_o   = res_cnt_q;
    assign res_sat_o   = res_sat_q;
    assign res_valid_o = res_valid_q;

    // Next-state, accumulator update and output-register load decision.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        res_d     = res_q;
        res_cnt_d = res_cnt_q;
        res_sat_d = res_sat_q;
        load      = 1'b0;

        unique case (state_q)
            ST_ACCUM: begin
                if (beat_acc) begin
                    if (prod_last_i && out_free) begin
                        res_d     = nsum;
                        res_cnt_d = cnt_inc;
                        res_sat_d = sat_q | ovf;
                        load      = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        sat_d     = 1'b0;
                    end else begin
                        acc_d = nsum;
                        cnt_d = cnt_inc;
                        sat_d = sat_q | ovf;
                        if (prod_last_i) begin
                            state_d = ST_STALL;
                        end
                    end
                end
            end
            ST_STALL: begin
                if (out_free) begin
                    res_d     = acc_q;
                    res_cnt_d = cnt_q;
                    res_sat_d = sat_q;
                    load      = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    sat_d     = 1'b0;
                    state_d   = ST_ACCUM;
                end
            end
        endcase

        // A load in the same cycle as a drain keeps the slot full with new data.
        res_valid_d = load | (res_valid_q & ~res_ready_i);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            res_q       <= '0;
            res_cnt_q   <= '0;
            res_sat_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            res_sat_q   <= res_sat_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_dot_acc.sv
// Bench for dot_acc: three instances with different widths share one stimulus
// stream; a frame-level model per instance is compared every cycle, and the
// directed scenarios also pin literal results.
module tb_dot_acc;

    localparam int NI = 3;
    localparam int AW [NI] = '{40, 34, 40};
    localparam int CW [NI] = '{8, 8, 2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] prod_i = '0;
    logic        prod_valid_i = 1'b0;
    logic        prod_last_i = 1'b0;
    logic        res_ready_i = 1'b1;
    bit          rnd = 1'b0;

    logic        rdy0, rdy1, rdy2;
    logic [39:0] res0;
    logic [33:0] res1;
    logic [39:0] res2;
    logic [7:0]  cnt0, cnt1;
    logic [1:0]  cnt2;
    logic        sat0, sat1, sat2;
    logic        vld0, vld1, vld2;

    int checks = 0;
    int errors = 0;

    dot_acc #(.ACC_W(40), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .prod_i(prod_i), .prod_valid_i(prod_valid_i),
        .prod_last_i(prod_last_i), .prod_ready_o(rdy0), .res_o(res0), .res_cnt_o(cnt0),
        .res_sat_o(sat0), .res_valid_o(vld0), .res_ready_i(res_ready_i));

    dot_acc #(.ACC_W(34), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .prod_i(prod_i), .prod_valid_i(prod_valid_i),
        .prod_last_i(prod_last_i), .prod_ready_o(rdy1), .res_o(res1), .res_cnt_o(cnt1),
        .res_sat_o(sat1), .res_valid_o(vld1), .res_ready_i(res_ready_i));

    dot_acc #(.ACC_W(40), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .prod_i(prod_i), .prod_valid_i(prod_valid_i),
        .prod_last_i(prod_last_i), .prod_ready_o(rdy2), .res_o(res2), .res_cnt_o(cnt2),
        .res_sat_o(sat2), .res_valid_o(vld2), .res_ready_i(res_ready_i));

    always #5 clk = ~clk;

    // Frame-level model: running sum, a parked finished frame, and an output slot.
    logic [63:0] m_acc  [NI];
    int          m_cnt  [NI];
    bit          m_sat  [NI];
    bit          m_pend [NI];
    logic [63:0] m_res  [NI];
    int          m_rcnt [NI];
    bit          m_rsat [NI];
    bit          m_rv   [NI];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < NI; i++) begin
                if (!rst_n) begin
                    m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_pend[i] = 0;
                    m_res[i] = 0; m_rcnt[i] = 0; m_rsat[i] = 0; m_rv[i] = 0;
                end else begin
                    logic [63:0] amax;
                    logic [63:0] s;
                    int          cmax;
                    bit          free;
                    bit          loaded;
                    amax   = (64'd1 << AW[i]) - 64'd1;
                    cmax   = (1 << CW[i]) - 1;
                    free   = !m_rv[i] || res_ready_i;
                    loaded = 0;
                    if (m_pend[i]) begin
                        if (free) begin
                            m_res[i] = m_acc[i]; m_rcnt[i] = m_cnt[i]; m_rsat[i] = m_sat[i];
                            m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
                            m_pend[i] = 0; loaded = 1;
                        end
                    end else if (prod_valid_i) begin
                        s = m_acc[i] + {32'd0, prod_i};
                        if (s > amax) begin
                            s = amax;
                            m_sat[i] = 1;
                        end
                        m_acc[i] = s;
                        if (m_cnt[i] < cmax) m_cnt[i]++;
                        if (prod_last_i) begin
                            if (free) begin
                                m_res[i] = m_acc[i]; m_rcnt[i] = m_cnt[i]; m_rsat[i] = m_sat[i];
                                m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
                                loaded = 1;
                            end else begin
                                m_pend[i] = 1;
                            end
                        end
                    end
                    if (loaded) m_rv[i] = 1;
                    else if (res_ready_i) m_rv[i] = 0;
                end
            end
        end
    end

    // Every cycle, all outputs of all instances against the model.
    initial begin
        forever begin
            logic [63:0] a_res [NI];
            logic [63:0] a_cnt [NI];
            logic        a_sat [NI];
            logic        a_vld [NI];
            logic        a_rdy [NI];
            @(posedge clk);
            #1;
            a_res[0] = 64'(res0); a_res[1] = 64'(res1); a_res[2] = 64'(res2);
            a_cnt[0] = 64'(cnt0); a_cnt[1] = 64'(cnt1); a_cnt[2] = 64'(cnt2);
            a_sat[0] = sat0; a_sat[1] = sat1; a_sat[2] = sat2;
            a_vld[0] = vld0; a_vld[1] = vld1; a_vld[2] = vld2;
            a_rdy[0] = rdy0; a_rdy[1] = rdy1; a_rdy[2] = rdy2;
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("dut%0d.prod_ready", i), 64'(a_rdy[i]), 64'(!m_pend[i]));
                chk($sformatf("dut%0d.res_valid", i), 64'(a_vld[i]), 64'(m_rv[i]));
                chk($sformatf("dut%0d.res", i), a_res[i], m_res[i]);
                chk($sformatf("dut%0d.res_cnt", i), a_cnt[i], 64'(m_rcnt[i]));
                chk($sformatf("dut%0d.res_sat", i), 64'(a_sat[i]), 64'(m_rsat[i]));
            end
        end
    end

    // Advance one cycle; inputs change 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
        if (rnd) res_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic beat(input logic [31:0] p, input logic l);
        int n;
        n = 0;
        prod_i = p; prod_last_i = l; prod_valid_i = 1'b1;
        while (!rdy0 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (!rdy0) begin
            errors++;
            $display("FAIL beat_wait: prod_ready stuck at 0 expected 1 at %0t", $time);
        end
        tick();
        prod_valid_i = 1'b0;
        prod_last_i  = 1'($urandom_range(0, 1));
        prod_i       = $urandom;
    endtask

    initial begin
        tick();
        tick();
        chk("reset.res_valid", 64'(vld0), 64'd0);
        chk("reset.prod_ready", 64'(rdy0), 64'd1);
        chk("reset.res", 64'(res0), 64'd0);
        rst_n = 1'b1;
        tick();

        // Four-beat frame.
        res_ready_i = 1'b1;
        beat(32'd3, 1'b0); beat(32'd5, 1'b0); beat(32'd7, 1'b0); beat(32'd9, 1'b1);
        chk("t1.res", 64'(res0), 64'd24);
        chk("t1.cnt", 64'(cnt0), 64'd4);
        chk("t1.sat", 64'(sat0), 64'd0);
        chk("t1.valid", 64'(vld0), 64'd1);
        chk("t1.cnt_w2", 64'(cnt2), 64'd3);
        tick();

        // Saturation in the 34-bit instance; the 40-bit one does not saturate.
        for (int k = 0; k < 5; k++) beat(32'hFFFF_FFFF, 1'(k == 4));
        chk("t2.res34", 64'(res1), 64'h3_FFFF_FFFF);
        chk("t2.sat34", 64'(sat1), 64'd1);
        chk("t2.cnt34", 64'(cnt1), 64'd5);
        chk("t2.res40", 64'(res0), 64'h4_FFFF_FFFB);
        chk("t2.sat40", 64'(sat0), 64'd0);
        tick();

        // Back-pressure: frame A held, frame B parks, then both drain.
        res_ready_i = 1'b0;
        beat(32'd10, 1'b0); beat(32'd20, 1'b1);
        chk("t3.a_res", 64'(res0), 64'd30);
        beat(32'd1, 1'b0); beat(32'd1, 1'b1);
        chk("t3.stall_ready", 64'(rdy0), 64'd0);
        tick(); tick();
        chk("t3.a_held", 64'(res0), 64'd30);
        res_ready_i = 1'b1;
        tick();
        chk("t3.b_res", 64'(res0), 64'd2);
        chk("t3.b_valid", 64'(vld0), 64'd1);
        chk("t3.ready_back", 64'(rdy0), 64'd1);
        tick();

        // Back-to-back single-beat frames.
        beat(32'd7, 1'b1);
        chk("t4.r7", 64'(res0), 64'd7);
        chk("t4.c7", 64'(cnt0), 64'd1);
        beat(32'd8, 1'b1);
        chk("t4.r8", 64'(res0), 64'd8);
        beat(32'd9, 1'b1);
        chk("t4.r9", 64'(res0), 64'd9);
        chk("t4.c9", 64'(cnt0), 64'd1);
        tick();

        // Beat-count saturation with a 2-bit counter.
        for (int k = 0; k < 6; k++) beat(32'd1, 1'(k == 5));
        chk("t5.cnt_w2", 64'(cnt2), 64'd3);
        chk("t5.res_w2", 64'(res2), 64'd6);
        chk("t5.cnt_w8", 64'(cnt0), 64'd6);
        tick();

        // Reset mid-frame discards the partial sum.
        beat(32'd100, 1'b0); beat(32'd200, 1'b0);
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t6.no_result", 64'(vld0), 64'd0);
        beat(32'd5, 1'b1);
        chk("t6.res", 64'(res0), 64'd5);
        chk("t6.cnt", 64'(cnt0), 64'd1);
        tick();

        // Randomized frames, gaps and consumer back-pressure.
        rnd = 1'b1;
        for (int f = 0; f < 300; f++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) tick();
                beat(($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom, 1'(k == len - 1));
            end
        end
        rnd = 1'b0;
        res_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
